relu_maxpool_2: RTL
===================

Name: relu_maxpool_2

Overview:
- Downstream stage of the 12-kernel second convolution layer.
- Consumes one 12-channel pixel (12 x 32-bit) per valid strobe, in row-major raster order.
- Per channel: applies ReLU, requantises to 16 bits with saturation, then 2x2/stride-2 max pooling.
- Emits pooled 12 x 16-bit pixels to the next layer, plus a frame-done strobe.

Parameters:
- IMG_W, 8, input feature-map width in pixels; even, >=2.
- IMG_H, 8, input feature-map height in pixels; even, >=2.
- FRAC_SHIFT, 8, arithmetic right shift applied in the 32->16-bit requantisation.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state.
- in_1 .. in_12  input  32 each  signed conv outputs, channels 1..12.
- valid  input  1  in_* hold one pixel this cycle.
- out_1 .. out_12  output  16 each  pooled values, non-negative.
- out_valid  output  1  one-cycle pulse; out_* hold a new pooled pixel.
- finish  output  1  one-cycle pulse with the last pooled pixel of a frame.

Behaviour:
- Reset values: out_* = 0, out_valid = 0, finish = 0, col = 0, row = 0, state = IDLE, hold registers = 0.
- Line-buffer contents are not reset.
- Requantisation, per channel, combinational on the input:
  - x[31] = 1 -> r = 0.
  - Otherwise y = x >>> FRAC_SHIFT; r = (y > 32767) ? 16'h7FFF : y[15:0].
- FSM, states IDLE and RUN:
  - IDLE -> RUN on the first valid.
  - RUN -> IDLE on the valid of pixel (IMG_W-1, IMG_H-1).
  - valid is processed identically in either state; the FSM only tracks frame activity.
- Counters:
  - col advances 0..IMG_W-1 on each valid and wraps to 0; row increments on the wrap.
  - row wraps to 0 after IMG_H-1, so frames may be back-to-back with no idle cycle.
- Pooling datapath, all 12 channels in parallel, acting only on valid cycles:
  - col even: hold[ch] <= r.
  - col odd: hmax = max(hold[ch], r).
  - row even, col odd: linebuf[ch][col>>1] <= hmax. Line buffer is IMG_W/2 entries x 16 bits per channel.
  - row odd, col odd: out_ch <= max(linebuf[ch][col>>1], hmax); out_valid <= 1 the next cycle.
- Latency: out_valid rises exactly 1 cycle after the valid of the bottom-right pixel of each 2x2 window.
- Output counts:
  - IMG_W/2 * IMG_H/2 out_valid pulses per frame.
  - out_* hold their value between pulses.
- finish asserts in the same cycle as the final out_valid of a frame; otherwise 0.
- Gaps: valid may drop for any number of cycles; counters, hold and line buffer retain state.
- No back-pressure: the consumer must accept every out_valid pulse.
- Comparisons are unsigned on the 16-bit post-ReLU values.
- Ties: equal values give that value.
- Reset mid-frame: everything returns to the reset values asynchronously; the next valid is treated as pixel (0,0).

Optional Feature:
- Macro RELU_MAXPOOL_SAT_CNT_EN.
- When defined:
  - Adds output port sat_count [15:0].
  - sat_count counts valid cycles in which at least one channel saturated to 16'h7FFF.
  - Sticks at 16'hFFFF; cleared by reset and on the cycle finish pulses, with that cycle's increment discarded.
- When undefined: no port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Package conv_pool_pkg holds:
  - NUM_CH = 12, IN_W = 32, OUT_W = 16, SAT_MAX = 16'h7FFF;
  - the state typedef {IDLE, RUN}.
- Sub-module relu_requant: combinational, one 32-bit input, one 16-bit output, parameter FRAC_SHIFT, plus a sat flag; instantiated 12 times.
- Counters, FSM, hold registers and line buffers stay in the top module.

Test Plan:
- Ramp pixel: all channels in = (row*8+col) << 8 over an 8x8 frame -> 16 out_valid pulses with values 9, 11, 13, 15, 25, ..., 63; finish coincides with the 16th pulse only.
- ReLU: channel 3 all 32'hFFFF_FF00 (negative) while other channels use the ramp -> out_3 = 0 on every pulse; the other channels are unaffected.
- Saturation: one pixel per window = 32'h0100_0000 -> that window outputs 16'h7FFF.
  - With RELU_MAXPOOL_SAT_CNT_EN, sat_count = 16 just before finish, and 0 the cycle after.
- Gapped valid: the ramp frame with random 0-5 idle cycles between pixels -> identical output sequence; each out_valid arrives 1 cycle after its window's last valid.
- Mid-frame reset: drive 20 pixels, pulse reset low, then a full new frame -> exactly 16 outputs, no stale line-buffer values, finish once.
- Back-to-back frames: two 8x8 frames with valid held high continuously -> 32 outputs, finish pulsed twice at outputs 16 and 32.

Source files
------------

// File: rtl/conv_pool_pkg.sv
// rtl/conv_pool_pkg.sv - shared widths, saturation limit and frame FSM state type
package conv_pool_pkg;
  localparam int          NUM_CH  = 12;
  localparam int          IN_W    = 32;
  localparam int          OUT_W   = 16;
  localparam logic [15:0] SAT_MAX = 16'h7FFF;

  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/relu_requant.sv
// rtl/relu_requant.sv - ReLU plus 32->16 bit requantisation with saturation flag
module relu_requant
  import conv_pool_pkg::*;
#(
  parameter int FRAC_SHIFT = 8
) (
  input  logic [IN_W-1:0]  x_i,
  output logic [OUT_W-1:0] r_o,
  output logic             sat_o
);

  logic signed [IN_W-1:0] y;
  assign y = $signed(x_i) >>> FRAC_SHIFT;

  // y is non-negative here, so any set bit above bit 14 means y > 32767
  always_comb begin
    r_o   = '0;
    sat_o = 1'b0;
    if (!x_i[IN_W-1]) begin
      if (|y[IN_W-1:OUT_W-1]) begin
        r_o   = SAT_MAX;
        sat_o = 1'b1;
      end else begin
        r_o = y[OUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/relu_maxpool_2.sv
// rtl/relu_maxpool_2.sv - 12-channel ReLU/requant/2x2 max-pool; RELU_MAXPOOL_SAT_CNT_EN adds sat_count
module relu_maxpool_2
  import conv_pool_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int FRAC_SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_1,
  input  logic [IN_W-1:0]  in_2,
  input  logic [IN_W-1:0]  in_3,
  input  logic [IN_W-1:0]  in_4,
  input  logic [IN_W-1:0]  in_5,
  input  logic [IN_W-1:0]  in_6,
  input  logic [IN_W-1:0]  in_7,
  input  logic [IN_W-1:0]  in_8,
  input  logic [IN_W-1:0]  in_9,
  input  logic [IN_W-1:0]  in_10,
  input  logic [IN_W-1:0]  in_11,
  input  logic [IN_W-1:0]  in_12,
  input  logic             valid,
  output logic [OUT_W-1:0] out_1,
  output logic [OUT_W-1:0] out_2,
  output logic [OUT_W-1:0] out_3,
  output logic [OUT_W-1:0] out_4,
  output logic [OUT_W-1:0] out_5,
  output logic [OUT_W-1:0] out_6,
  output logic [OUT_W-1:0] out_7,
  output logic [OUT_W-1:0] out_8,
  output logic [OUT_W-1:0] out_9,
  output logic [OUT_W-1:0] out_10,
  output logic [OUT_W-1:0] out_11,
  output logic [OUT_W-1:0] out_12,
  output logic             out_valid,
  output logic             finish
`ifdef RELU_MAXPOOL_SAT_CNT_EN
  ,
  output logic [15:0]      sat_count
`endif
);

  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_N = IMG_W / 2;
  localparam int LW   = (LB_N > 1) ? $clog2(LB_N) : 1;

  logic [IN_W-1:0]   in_a   [NUM_CH];
  logic [OUT_W-1:0]  r      [NUM_CH];
  logic [NUM_CH-1:0] sat;
  logic [OUT_W-1:0]  hold_q [NUM_CH];
  logic [OUT_W-1:0]  out_q  [NUM_CH];
  logic [OUT_W-1:0]  hmax   [NUM_CH];
  logic [OUT_W-1:0]  pool   [NUM_CH];
  logic [OUT_W-1:0]  lb_q   [NUM_CH][LB_N];

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           out_valid_q, finish_q;
  logic           col_last, row_last;
  logic [LW-1:0]  lb_idx;

  assign in_a[0]  = in_1;   assign in_a[1]  = in_2;   assign in_a[2]  = in_3;
  assign in_a[3]  = in_4;   assign in_a[4]  = in_5;   assign in_a[5]  = in_6;
  assign in_a[6]  = in_7;   assign in_a[7]  = in_8;   assign in_a[8]  = in_9;
  assign in_a[9]  = in_10;  assign in_a[10] = in_11;  assign in_a[11] = in_12;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_rq
    relu_requant #(.FRAC_SHIFT(FRAC_SHIFT)) u_rq (
      .x_i  (in_a[g]),
      .r_o  (r[g]),
      .sat_o(sat[g])
    );
  end

  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign lb_idx   = LW'(col_q >> 1);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (valid) begin
      col_d   = col_last ? '0 : col_q + 1'b1;
      state_d = (col_last && row_last) ? IDLE : RUN;
      if (col_last) row_d = row_last ? '0 : row_q + 1'b1;
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      hmax[ch] = (hold_q[ch] > r[ch]) ? hold_q[ch] : r[ch];
      pool[ch] = (lb_q[ch][lb_idx] > hmax[ch]) ? lb_q[ch][lb_idx] : hmax[ch];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        hold_q[ch] <= '0;
        out_q[ch]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= valid && col_q[0] && row_q[0];
      finish_q    <= valid && col_last && row_last;
      if (valid) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (!col_q[0]) hold_q[ch] <= r[ch];
          else if (row_q[0]) out_q[ch] <= pool[ch];
        end
      end
    end
  end

  // Line buffer is storage only; its contents are always rewritten on an even row before use
  always_ff @(posedge clk) begin
    if (valid && col_q[0] && !row_q[0]) begin
      for (int ch = 0; ch < NUM_CH; ch++) lb_q[ch][lb_idx] <= hmax[ch];
    end
  end

  assign out_1  = out_q[0];   assign out_2  = out_q[1];   assign out_3  = out_q[2];
  assign out_4  = out_q[3];   assign out_5  = out_q[4];   assign out_6  = out_q[5];
  assign out_7  = out_q[6];   assign out_8  = out_q[7];   assign out_9  = out_q[8];
  assign out_10 = out_q[9];   assign out_11 = out_q[10];  assign out_12 = out_q[11];
  assign out_valid = out_valid_q;
  assign finish    = finish_q;

`ifdef RELU_MAXPOOL_SAT_CNT_EN
  logic [15:0] sat_count_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sat_count_q <= '0;
    else if (finish_q) sat_count_q <= '0;
    else if (valid && (|sat) && (sat_count_q != 16'hFFFF)) sat_count_q <= sat_count_q + 1'b1;
  end
  assign sat_count = sat_count_q;
`else
  logic unused_sat;
  assign unused_sat = ^sat;
`endif

endmodule
